// File: rtl/axi_probe_pkg.sv
// Shared definitions for the UART probe's AXI4-Lite target: response codes,
// FSM state encodings and the AXI_CTRL field positions used by the probe.
package axi_probe_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

  // AXI_CTRL register layout on the probe side
  localparam int AXI_CTRL_GO_BIT   = 0;
  localparam int AXI_CTRL_WR_BIT   = 1;
  localparam int AXI_CTRL_BUSY_BIT = 2;
  localparam int AXI_CTRL_RESP_LSB = 4;
  localparam int AXI_CTRL_RESP_W   = 2;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_probe_target_mem.sv
// DEPTH x 32 register file with byte enables, async reset to MEM_RESET,
// one write port and one combinational read port (read sees pre-write data).
module axi_probe_target_mem
  import axi_probe_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] MEM_RESET = 32'h0000_0000,
  localparam int         IDX_W     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       wstrb_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= MEM_RESET;
    end else if (we_i) begin
      mem_q[waddr_i] <= merge_bytes(mem_q[waddr_i], wdata_i, wstrb_i);
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_probe_target.sv
// AXI4-Lite-subset target terminating the UART probe's master port.
// Define AXI_PROBE_TARGET_DECERR_EN to answer out-of-range accesses with DECERR.
module axi_probe_target
  import axi_probe_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] MEM_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        m_aresetn,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awsize,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arsize,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);

  localparam int IDX_W = $clog2(DEPTH);

  wr_state_e   w_state_q, w_state_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d;
  rd_state_e   r_state_q, r_state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic [31:0] c_addr, c_data, mem_rdata;
  logic [3:0]  c_strb;
  logic        commit, mem_we, aw_hs, w_hs, wr_oor, rd_oor;
  logic        unused_bits;

  assign s_axi_awready = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_D);
  assign s_axi_wready  = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_A);
  assign s_axi_arready = (r_state_q == R_IDLE);
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_rvalid  = (r_state_q == R_RESP);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign wr_oor = (c_addr[31:IDX_W+2] != '0);
  assign rd_oor = (s_axi_araddr[31:IDX_W+2] != '0);

  // Without the DECERR option the upper address bits are intentionally dropped.
  assign unused_bits = ^{s_axi_awsize, s_axi_arsize, c_addr, s_axi_araddr, wr_oor, rd_oor};

  always_comb begin
    w_state_d = w_state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;
    c_addr    = s_axi_awaddr;
    c_data    = s_axi_wdata;
    c_strb    = s_axi_wstrb;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
        end else if (aw_hs) begin
          awaddr_d  = s_axi_awaddr;
          w_state_d = W_HAVE_A;
        end else if (w_hs) begin
          wdata_d   = s_axi_wdata;
          wstrb_d   = s_axi_wstrb;
          w_state_d = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        c_addr = awaddr_q;
        commit = w_hs;
      end
      W_HAVE_D: begin
        c_data = wdata_q;
        c_strb = wstrb_q;
        commit = aw_hs;
      end
      W_RESP: if (s_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    if (commit) begin
      w_state_d = W_RESP;
`ifdef AXI_PROBE_TARGET_DECERR_EN
      bresp_d = wr_oor ? RESP_DECERR : RESP_OKAY;
`else
      bresp_d = RESP_OKAY;
`endif
    end
  end

`ifdef AXI_PROBE_TARGET_DECERR_EN
  assign mem_we = commit && !wr_oor;
`else
  assign mem_we = commit;
`endif

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: if (s_axi_arvalid) begin
`ifdef AXI_PROBE_TARGET_DECERR_EN
        rdata_d = rd_oor ? 32'h0 : mem_rdata;
        rresp_d = rd_oor ? RESP_DECERR : RESP_OKAY;
`else
        rdata_d = mem_rdata;
        rresp_d = RESP_OKAY;
`endif
        r_state_d = R_RESP;
      end
      R_RESP: if (s_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      w_state_q <= W_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  axi_probe_target_mem #(
    .DEPTH     (DEPTH),
    .MEM_RESET (MEM_RESET)
  ) u_mem (
    .clk     (clk),
    .rst_n   (m_aresetn),
    .we_i    (mem_we),
    .waddr_i (c_addr[IDX_W+1:2]),
    .wdata_i (c_data),
    .wstrb_i (c_strb),
    .raddr_i (s_axi_araddr[IDX_W+1:2]),
    .rdata_o (mem_rdata)
  );

endmodule
